// File: rtl/ascon_perm_iterator_pkg.sv
// Shared types and constants for the Ascon permutation round driver.
// Includes the 320-bit state type, round counts, FSM encoding and a rotate helper.
package ascon_perm_iterator_pkg;

  localparam int ROUNDS_A = 12;
  localparam int ROUNDS_B = 6;

  // Word 0 is x0 of the Ascon state, word 4 is x4.
  typedef logic [4:0][63:0] state_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} perm_fsm_t;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_perm_iterator_if.sv
// Start/done handshake bundle between the mode controller (master) and the
// permutation round driver (slave).
interface ascon_perm_iterator_if;
  import ascon_perm_iterator_pkg::*;

  logic       start_i;
  logic [3:0] nb_rounds_i;
  state_t     state_i;
  state_t     state_o;
  logic [3:0] round_o;
  logic       busy_o;
  logic       done_o;

  modport master (
    output start_i, nb_rounds_i, state_i,
    input  state_o, round_o, busy_o, done_o
  );

  modport slave (
    input  start_i, nb_rounds_i, state_i,
    output state_o, round_o, busy_o, done_o
  );

endinterface

// File: rtl/ascon_perm_iterator_round.sv
// Combinational single Ascon round: constant addition, 5-bit S-box layer and
// linear diffusion layer. round_i is the index within the 12-round schedule.
module ascon_perm_iterator_round
  import ascon_perm_iterator_pkg::*;
(
  input  state_t     state_i,
  input  logic [3:0] round_i,
  output state_t     state_o
);

  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;

  always_comb begin
    x0 = state_i[0];
    x1 = state_i[1];
    x2 = state_i[2];
    x3 = state_i[3];
    x4 = state_i[4];

    // Round constant ((15 - i) << 4) | i, which for a 4-bit i is {~i, i}.
    x2 = x2 ^ {56'h0, ~round_i, round_i};

    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    state_o[0] = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    state_o[1] = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    state_o[2] = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    state_o[3] = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    state_o[4] = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
  end

endmodule

// File: rtl/ascon_perm_iterator.sv
// Sequential round driver applying p^a / p^b to a registered Ascon state.
// Define ASCON_UNROLL2_EN to chain two round instances and retire two rounds per cycle.
module ascon_perm_iterator
  import ascon_perm_iterator_pkg::*;
#(
  parameter int MAX_ROUNDS = ROUNDS_A
) (
  input  logic                   clock_i,
  input  logic                   resetb_i,
  ascon_perm_iterator_if.slave   bus
);

  localparam logic [3:0] LAST_CNT = 4'(MAX_ROUNDS);

  perm_fsm_t  fsm_q, fsm_d;
  logic [3:0] cnt_q, cnt_d;
  state_t     state_q, state_d;

  logic [3:0] n_clamped;
  state_t     round0_out;
  state_t     run_state;
  logic [3:0] run_cnt;

  assign n_clamped = (bus.nb_rounds_i > LAST_CNT) ? LAST_CNT : bus.nb_rounds_i;

  ascon_perm_iterator_round u_round0 (
    .state_i (state_q),
    .round_i (cnt_q),
    .state_o (round0_out)
  );

`ifdef ASCON_UNROLL2_EN
  state_t round1_out;

  ascon_perm_iterator_round u_round1 (
    .state_i (round0_out),
    .round_i (cnt_q + 4'd1),
    .state_o (round1_out)
  );

  // With a single round left the second instance's output is discarded.
  always_comb begin
    run_state = round1_out;
    run_cnt   = cnt_q + 4'd2;
    if (cnt_q == LAST_CNT - 4'd1) begin
      run_state = round0_out;
      run_cnt   = cnt_q + 4'd1;
    end
  end
`else
  always_comb begin
    run_state = round0_out;
    run_cnt   = cnt_q + 4'd1;
  end
`endif

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    case (fsm_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = bus.state_i;
          cnt_d   = LAST_CNT - n_clamped;
          fsm_d   = (n_clamped == 4'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        state_d = run_state;
        cnt_d   = run_cnt;
        if (run_cnt >= LAST_CNT) fsm_d = DONE;
      end
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= IDLE;
      cnt_q   <= 4'd0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign bus.state_o = state_q;
  assign bus.round_o = cnt_q;
  assign bus.busy_o  = (fsm_q == RUN);
  assign bus.done_o  = (fsm_q == DONE);

endmodule

// File: tb/tb_ascon_perm_iterator.sv
// Self-checking bench for ascon_perm_iterator: table-driven runs, random runs
// and hand-written handshake/reset sequences against a table-based Ascon model.
module tb_ascon_perm_iterator;
  import ascon_perm_iterator_pkg::*;

`ifdef ASCON_UNROLL2_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam bit UNR = (STEP == 2);

  logic clk = 1'b0;
  logic resetb;
  int   checks = 0;
  int   failures = 0;

  ascon_perm_iterator_if bus ();

  ascon_perm_iterator dut (
    .clock_i  (clk),
    .resetb_i (resetb),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int unsigned sbox_tbl [32] = '{
    32'h04, 32'h0b, 32'h1f, 32'h14, 32'h1a, 32'h15, 32'h09, 32'h02,
    32'h1b, 32'h05, 32'h08, 32'h12, 32'h1d, 32'h03, 32'h06, 32'h1c,
    32'h1e, 32'h13, 32'h07, 32'h0e, 32'h00, 32'h0d, 32'h11, 32'h18,
    32'h10, 32'h0c, 32'h01, 32'h19, 32'h16, 32'h0a, 32'h0f, 32'h17
  };
  int rot_a [5] = '{19, 61, 1, 10, 7};
  int rot_b [5] = '{28, 39, 6, 17, 41};

  typedef struct {
    logic [3:0] nb;
    bit         rand_state;
    int         exp_lat;
    int         exp_first;
  } vec_t;

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    logic [127:0] d;
    d = {v, v} >> n;
    return d[63:0];
  endfunction

  // Reference round: S-box applied column by column via the lookup table.
  function automatic state_t model_round(input state_t s, input int r);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col;
    logic [4:0]  sub;
    for (int i = 0; i < 5; i++) x[i] = s[i];
    x[2] = x[2] ^ 64'((15 - r) * 16 + r);
    for (int b = 0; b < 64; b++) begin
      col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
      sub = 5'(sbox_tbl[col]);
      for (int i = 0; i < 5; i++) y[i][b] = sub[4 - i];
    end
    for (int i = 0; i < 5; i++) s[i] = y[i] ^ rotr(y[i], rot_a[i]) ^ rotr(y[i], rot_b[i]);
    return s;
  endfunction

  function automatic state_t model_perm(input state_t s, input int nb);
    int n;
    n = (nb > 12) ? 12 : nb;
    for (int r = 12 - n; r < 12; r++) s = model_round(s, r);
    return s;
  endfunction

  function automatic state_t rand_state();
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[i*32 +: 32] = $urandom();
    return state_t'(v);
  endfunction

  function automatic int lat_for(input int nb);
    int n;
    n = (nb > 12) ? 12 : nb;
    return UNR ? ((n + 1) / 2 + 1) : (n + 1);
  endfunction

  task automatic checkOutput(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts one permutation from a post-edge slot and follows it to done_o.
  task automatic applyStimulus(input string tag, input logic [3:0] nb, input state_t st,
                               input int exp_lat, input int exp_first, output state_t result);
    int  k;
    int  exp_round;
    bit  seen_done;
    exp_round       = exp_first;
    bus.start_i     = 1'b1;
    bus.nb_rounds_i = nb;
    bus.state_i     = st;
    k = 0;
    seen_done = 1'b0;
    while (!seen_done && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) begin
        bus.start_i     = 1'b0;
        bus.state_i     = rand_state();
        bus.nb_rounds_i = 4'($urandom_range(0, 15));
      end
      checkOutput({tag, "_busy_done_overlap"}, {319'h0, bus.busy_o & bus.done_o}, 320'h0);
      if (bus.busy_o) begin
        checkOutput({tag, "_round"}, {316'h0, bus.round_o}, 320'(exp_round));
        exp_round += STEP;
      end
      if (bus.done_o) seen_done = 1'b1;
    end
    checkOutput({tag, "_latency"}, 320'(k), 320'(exp_lat));
    checkOutput({tag, "_state"}, bus.state_o, model_perm(st, int'(nb)));
    result = bus.state_o;
    @(posedge clk); #1;
    checkOutput({tag, "_done_pulse"}, {318'h0, bus.done_o, bus.busy_o}, 320'h0);
  endtask

  initial begin
    vec_t   vecs [8];
    state_t st, res, res12, res15, sa, sb;
    int     k;
    bit     hit;

    vecs[0] = '{4'd12, 1'b0, UNR ? 7 : 13, 0};
    vecs[1] = '{4'd6,  1'b1, UNR ? 4 : 7,  6};
    vecs[2] = '{4'd0,  1'b1, 1,            12};
    vecs[3] = '{4'd15, 1'b0, UNR ? 7 : 13, 0};
    vecs[4] = '{4'd8,  1'b1, UNR ? 5 : 9,  4};
    vecs[5] = '{4'd1,  1'b1, 2,            11};
    vecs[6] = '{4'd13, 1'b1, UNR ? 7 : 13, 0};
    vecs[7] = '{4'd3,  1'b1, UNR ? 3 : 4,  9};

    resetb          = 1'b0;
    bus.start_i     = 1'b0;
    bus.nb_rounds_i = 4'd0;
    bus.state_i     = '0;
    #1;
    checkOutput("reset_state", bus.state_o, 320'h0);
    checkOutput("reset_flags", {314'h0, bus.round_o, bus.busy_o, bus.done_o}, 320'h0);
    @(posedge clk);
    @(posedge clk); #1;
    resetb = 1'b1;
    @(posedge clk); #1;

    res12 = '0;
    res15 = '0;
    for (int i = 0; i < 8; i++) begin
      st = vecs[i].rand_state ? rand_state() : state_t'('0);
      applyStimulus($sformatf("vec%0d", i), vecs[i].nb, st, vecs[i].exp_lat, vecs[i].exp_first, res);
      if (i == 0) res12 = res;
      if (i == 3) res15 = res;
    end
    checkOutput("nb15_equals_nb12", res15, res12);

    for (int i = 0; i < 6; i++) begin
      logic [3:0] nb;
      int         n;
      nb = 4'($urandom_range(0, 15));
      n  = (nb > 12) ? 12 : int'(nb);
      applyStimulus($sformatf("rand%0d", i), nb, rand_state(), lat_for(int'(nb)), 12 - n, res);
    end

    // start_i held high with a changing state_i: only the first sample counts.
    sa = rand_state();
    sb = rand_state();
    bus.start_i     = 1'b1;
    bus.nb_rounds_i = 4'd12;
    bus.state_i     = sa;
    k = 0;
    hit = 1'b0;
    while (!hit && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (bus.done_o) hit = 1'b1;
      else bus.state_i = rand_state();
    end
    checkOutput("held_latency", 320'(k), 320'(UNR ? 7 : 13));
    checkOutput("held_state", bus.state_o, model_perm(sa, 12));
    bus.state_i = sb;
    @(posedge clk); #1;
    checkOutput("held_idle_gap", {318'h0, bus.busy_o, bus.done_o}, 320'h0);
    @(posedge clk); #1;
    checkOutput("held_restart_busy", {319'h0, bus.busy_o}, 320'h1);
    bus.start_i = 1'b0;
    bus.state_i = rand_state();
    k = 1;
    hit = 1'b0;
    while (!hit && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (bus.done_o) hit = 1'b1;
    end
    checkOutput("held_second_latency", 320'(k), 320'(UNR ? 7 : 13));
    checkOutput("held_second_state", bus.state_o, model_perm(sb, 12));
    @(posedge clk); #1;

    // Asynchronous abort in the middle of p^12.
    bus.start_i     = 1'b1;
    bus.nb_rounds_i = 4'd12;
    bus.state_i     = rand_state();
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      if (bus.busy_o && bus.round_o >= 4'd5) hit = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    checkOutput("abort_reached_round5", {319'h0, hit}, 320'h1);
    #2 resetb = 1'b0;
    #1;
    checkOutput("abort_state", bus.state_o, 320'h0);
    checkOutput("abort_flags", {314'h0, bus.round_o, bus.busy_o, bus.done_o}, 320'h0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checkOutput("abort_no_done", {319'h0, bus.done_o}, 320'h0);
    end
    resetb = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_idle_after", {318'h0, bus.busy_o, bus.done_o}, 320'h0);
    applyStimulus("post_abort", 4'd12, rand_state(), UNR ? 7 : 13, 0, res);

    // Back-to-back p^12 then p^8, second start in the cycle after done_o.
    applyStimulus("b2b_a", 4'd12, rand_state(), UNR ? 7 : 13, 0, res);
    applyStimulus("b2b_b", 4'd8, rand_state(), UNR ? 5 : 9, 4, res);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
